// File: rtl/aoi_sweep_pkg.sv
// Shared types and the golden AOI model for the exhaustive sweep engine.
// f = ~(OR over pairs of x[2i+1] & x[2i]).
package aoi_sweep_pkg;
   localparam int PAIRS_MIN = 1;
   localparam int PAIRS_MAX = 6;
   localparam int LAT_MIN   = 1;
   localparam int LAT_MAX   = 8;
   localparam int VEC_MAX   = 2 * PAIRS_MAX;

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_e;

   function automatic logic aoi_golden(input logic [VEC_MAX-1:0] vec, input int pairs);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < PAIRS_MAX; i++)
         if (i < pairs) acc = acc | (vec[2*i+1] & vec[2*i]);
      return ~acc;
   endfunction
endpackage

// File: rtl/aoi_sweep_engine_if.sv
// Control, stimulus and result signals of the sweep engine.
// The engine side is the master; the bench / gate under test is the slave.
interface aoi_sweep_engine_if #(
   parameter int N     = 4,
   parameter int ERR_W = 8
);
   logic             start;
   logic             abort;
   logic [N-1:0]     stim;
   logic             stim_valid;
   logic             dut_f;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [N-1:0]     first_err_vec;
   logic             first_err_valid;

   modport master (
      input  start, abort, dut_f,
      output stim, stim_valid, busy, done, pass, err_cnt, first_err_vec, first_err_valid
   );
   modport slave (
      output start, abort, dut_f,
      input  stim, stim_valid, busy, done, pass, err_cnt, first_err_vec, first_err_valid
   );
endinterface

// File: rtl/aoi_delay_line.sv
// DEPTH-stage shift register with synchronous clear; aligns issued
// vectors and their expected bits with the DUT response latency.
module aoi_delay_line #(
   parameter int DEPTH = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);
   logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = din;
      for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
      if (clr) pipe_d = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) pipe_q <= '0;
      else     pipe_q <= pipe_d;
   end

   assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/aoi_sweep_engine.sv
// Exhaustive sweep of a PAIRS-term AOI gate: drives all 2^N vectors, checks the
// response LAT cycles later against the golden model, and reports pass/fail.
module aoi_sweep_engine
   import aoi_sweep_pkg::*;
#(
   parameter int PAIRS = 2,
   parameter int LAT   = 1,
   parameter int ERR_W = 8
) (
   input  logic clk,
   input  logic rst,
   aoi_sweep_engine_if.master bus
);
   localparam int N  = 2 * PAIRS;
   localparam int CW = N + 1;
   localparam int DW = N + 2;
   localparam logic [CW-1:0]    LAST_VEC   = {1'b0, {N{1'b1}}};
   localparam logic [CW-1:0]    LAST_DRAIN = CW'(LAT - 1);
   localparam logic [ERR_W-1:0] ERR_MAX    = '1;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [N-1:0]     fvec_q, fvec_d;
   logic             fval_q, fval_d;

   logic               issue_vld, issue_exp, busy, idle_or_done, dl_clr;
   logic [N-1:0]       issue_stim, d_stim;
   logic [VEC_MAX-1:0] gold_vec;
   logic [DW-1:0]      dl_out;
   logic               d_vld, d_exp;

   assign issue_vld    = (state_q == SWEEP);
   assign issue_stim   = issue_vld ? cnt_q[N-1:0] : '0;
   assign busy         = (state_q == SWEEP) || (state_q == DRAIN);
   assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
   // Flush on abort so a later sweep never sees stale in-flight vectors.
   assign dl_clr       = (idle_or_done && bus.start) || (busy && bus.abort);

   always_comb begin
      gold_vec         = '0;
      gold_vec[N-1:0]  = issue_stim;
   end
   assign issue_exp = aoi_golden(gold_vec, PAIRS);

   aoi_delay_line #(.DEPTH(LAT), .WIDTH(DW)) u_dly (
      .clk  (clk),
      .rst  (rst),
      .clr  (dl_clr),
      .din  ({issue_vld, issue_exp, issue_stim}),
      .dout (dl_out)
   );
   assign {d_vld, d_exp, d_stim} = dl_out;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fvec_d  = fvec_q;
      fval_d  = fval_q;
      if (d_vld && (bus.dut_f != d_exp)) begin
         if (err_q != ERR_MAX) err_d = err_q + 1'b1;
         if (!fval_q) begin
            fval_d = 1'b1;
            fvec_d = d_stim;
         end
      end
      case (state_q)
         IDLE, DONE: if (bus.start) begin
            state_d = SWEEP;
            cnt_d   = '0;
            err_d   = '0;
            fvec_d  = '0;
            fval_d  = 1'b0;
         end
         SWEEP: begin
            if (bus.abort)              state_d = IDLE;
            else if (cnt_q == LAST_VEC) begin
               state_d = DRAIN;
               cnt_d   = '0;
            end
            else                        cnt_d = cnt_q + 1'b1;
         end
         DRAIN: begin
            if (bus.abort)                state_d = IDLE;
            else if (cnt_q == LAST_DRAIN) state_d = DONE;
            else                          cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= '0;
         fvec_q  <= '0;
         fval_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fvec_q  <= fvec_d;
         fval_q  <= fval_d;
      end
   end

   assign bus.stim            = issue_stim;
   assign bus.stim_valid      = issue_vld;
   assign bus.busy            = busy;
   assign bus.done            = (state_q == DONE);
   assign bus.pass            = (state_q == DONE) && (err_q == '0);
   assign bus.err_cnt         = err_q;
   assign bus.first_err_vec   = fvec_q;
   assign bus.first_err_valid = fval_q;
endmodule

// File: doc/aoi_sweep_engine.md
Name: aoi_sweep_engine

Overview:
- Self-checking exhaustive-stimulus engine for a parametrised AND-OR-INVERT gate with PAIRS two-input AND terms: f = ~(OR over i of (x[2i+1] & x[2i])).
- On start it drives every input combination in ascending binary order and compares the DUT response, after a fixed latency, against a golden AOI model.
- It counts mismatches, captures the first failing vector and reports pass/fail.
- It sits in the gate-characterisation bench layer, beside the AOI CMOS gate models, and replaces hand-written exhaustive stimulus lists.

Parameters:
- PAIRS, 2, number of AND terms; input vector width N = 2*PAIRS; legal range 1..6.
- LAT, 1, DUT response latency in clock cycles; legal range 1..8.
- ERR_W, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  begin sweep; honoured only in IDLE or DONE.
- abort  input  1  terminate sweep; return to IDLE without done.
- stim  output  N  stimulus vector to the DUT; for PAIRS=2 the order is {a,b,c,d}, with pairs (a,b) and (c,d).
- stim_valid  output  1  stim carries a sweep vector this cycle.
- dut_f  input  1  DUT output, corresponding to the stim presented LAT cycles earlier.
- busy  output  1  sweep or drain in progress.
- done  output  1  sweep complete; held until the next start or reset.
- pass  output  1  done && err_cnt==0.
- err_cnt  output  ERR_W  mismatch count; saturates at 2^ERR_W-1.
- first_err_vec  output  N  stim value of the first mismatch.
- first_err_valid  output  1  first_err_vec is meaningful.

Behaviour:
- Reset (synchronous, active-high): state=IDLE. All outputs are 0: stim, stim_valid, busy, done, pass, err_cnt, first_err_vec, first_err_valid. The delay line is cleared. Reset has priority over start and abort in every state, including mid-sweep.
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE or DONE with start=1 at cycle t:
  - next state is SWEEP;
  - err_cnt, first_err_* and done are cleared;
  - vector counter is 0.
- SWEEP: vector k = 0..V-1, with V = 2^N, is driven on stim during cycle t+1+k with stim_valid=1. After vector V-1 the state moves to DRAIN.
- DRAIN: lasts LAT cycles with stim=0 and stim_valid=0, then the state moves to DONE.
- Timing: busy=1 for cycles t+1 .. t+V+LAT. done=1 from cycle t+V+LAT+1.
- Golden model: the expected bit is computed from stim in the issue cycle. The expected bit, stim_valid and stim travel through a LAT-stage delay line.
- Compare: whenever the delayed valid is high, compare dut_f against the delayed expected bit. On mismatch:
  - err_cnt increments, saturating at its maximum;
  - if first_err_valid=0, capture the delayed stim into first_err_vec and set first_err_valid.
- Counter arithmetic: the vector counter is N+1 bits wide so that the terminal count V-1 is detected without wrap-around aliasing.
- start while busy: ignored, with no restart or clear.
- abort in SWEEP or DRAIN: next cycle state=IDLE, busy=0, stim_valid=0, and the delay line is flushed. done stays 0. err_cnt and first_err_* keep their values for debug. abort in IDLE or DONE has no effect.
- start and abort in the same cycle while in IDLE or DONE: start wins.
- DONE holds err_cnt, first_err_* and pass until the next start, reset or abort-free restart.

Decomposition:
- Package aoi_sweep_pkg contains:
  - state enum {IDLE, SWEEP, DRAIN, DONE};
  - function aoi_golden(vec, PAIRS) returning the expected f;
  - localparam limits for PAIRS and LAT.
- One sub-module, aoi_delay_line: a parametrised DEPTH x WIDTH shift register with synchronous clear, carrying {valid, expected, stim}.

Test Plan:
1. PAIRS=2, LAT=1, DUT is a correct AOI model registered once; start at cycle 0 -> stim counts 0..15 in cycles 1..16; busy covers cycles 1..17; done=1 and pass=1 at cycle 18; err_cnt=0; first_err_valid=0.
2. PAIRS=2, LAT=1, dut_f stuck at 0 -> err_cnt=9, first_err_vec=4'b0000, pass=0. Then dut_f stuck at 1 -> err_cnt=7, first_err_vec=4'b0011.
3. PAIRS=3, LAT=3, correct DUT delayed by 3 -> 64 vectors, done at cycle 68, pass=1. Then the same engine with the DUT delayed by 2 -> err_cnt>0 and first_err_valid=1.
4. ERR_W=3, PAIRS=2, dut_f stuck at 0 -> err_cnt saturates at 7, not wrapping to 1.
5. rst asserted at vector 7 -> next cycle all outputs 0 and state IDLE. Later start -> full clean sweep with pass=1.
6. start reasserted mid-sweep -> ignored and the vector sequence is unbroken. abort at vector 5 -> IDLE next cycle with done=0. start in DONE -> counters cleared and a new sweep runs.
